core_if: RTL and testbench
==========================

# core_if

Instruction fetch stage of the i2d core. It owns the fetch PC and issues word requests on the instruction-memory bus. It presents one instruction per cycle to the decode stage as `if_pc`/`if_instr`, and holds that instruction while decode is halted. Branch redirects, pipeline flushes and fetch bus errors are resolved here, and a NOP bubble is substituted whenever no valid instruction is available.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: asynchronous active-low reset.
- `id_halt` in 1: decode stalled; `if_pc`/`if_instr` must hold.
- `id_flush` in 1: discard fetched, unconsumed instructions.
- `branch` in 1: redirect request.
- `branch_target` in addr_t: redirect address; bits [1:0] are ignored.
- `if_pc` out addr_t: PC of presented instruction.
- `if_instr` out instr_t: presented instruction or NOP bubble.
- `if_err` out 1: presented slot came from a bus error.
- `imem_req` out 1: fetch request.
- `imem_addr` out addr_t: word-aligned fetch address.
- `imem_ack` in 1: request complete this cycle.
- `imem_data` in instr_t: fetched word; valid with `imem_ack`.
- `imem_err` in 1: bus error; qualified by `imem_ack`.

## Operation
- **Output slot**
  - Registers: `if_pc`, `if_instr`, `if_err`, internal `slot_valid`.
  - Decode consumes the slot at every edge where `id_halt`=0.
  - The slot reloads at exactly those edges, from buffer head, else the acked word, else a bubble. A bubble is `{OPCODE_NOP,26'(0)}` with `slot_valid`=0.
- **Bus rules**
  - Once raised, `imem_req` and `imem_addr` stay stable until `imem_ack`.
  - Ack may arrive in the same cycle as req. There is one outstanding request maximum.
  - The fetch PC advances by 4 on each accepted ack.
- **FSM**
  - RST: entered on reset. Next cycle goes to FETCH with fetch_pc=`RESET_PC`.
  - FETCH: `imem_req`=1 when there is room for the result, i.e. the slot is consumable/empty or the buffer has a free entry.
  - DRAIN: a redirect arrived with a request in flight. `imem_req` stays high on the old address, and the acked data is discarded. Then go to FETCH at the redirect target.
  - ERR: entered on `imem_ack`&`imem_err`. The slot loads `{OPCODE_NOP,26'(3)}` with `if_pc`=faulting address and `if_err`=1. No requests are issued until `branch`, then go to FETCH (or DRAIN if needed).
- **Redirect (`branch`=1)**
  - fetch_pc <= `{branch_target[31:2],2'b00}`.
  - The slot becomes a bubble and the buffer clears.
  - `branch` overrides `id_halt`.
- **Flush (`id_flush`=1, `branch`=0)**
  - The slot becomes a bubble and the buffer clears.
  - Fetch restarts at the PC of the oldest discarded valid instruction: slot, else buffer head, else the current fetch_pc.
  - This takes the DRAIN path if a request is in flight.
- **Simultaneous events**
  - `branch` and `id_flush` together: `branch` wins.
  - A redirect in the same cycle as an ack: the acked data is discarded and the new fetch starts the next cycle. No DRAIN state is needed.
  - `imem_err` arriving during DRAIN is ignored.
- **Reset mid-request:** all state clears immediately and `imem_req` drops. The bus must tolerate an abandoned request on reset only.

## Timing
- Reset values:
  - `if_pc`=0, `if_instr`=`{OPCODE_NOP,26'(0)}`, `if_err`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - Buffer empty.
- Fetch latency: `imem_ack` at edge N puts the instruction on `if_pc`/`if_instr` after edge N, provided the slot is consumable.
- Throughput: one instruction per cycle with zero-wait-state memory (same-cycle ack).
- Redirect penalty:
  - Target is requested in the cycle after `branch` when no request is in flight.
  - Otherwise it is requested in the cycle after the drained ack.

## Configuration
- **`I2D_IF_PREFETCH_EN` defined:** a 2-entry FIFO sits between the bus and the slot.
  - Fetching continues while `id_halt`=1 until the FIFO is full.
  - The FIFO cannot over/underflow. A request is issued only if a free entry exists, counting the in-flight request.
  - FIFO wrap-around is by 1-bit pointers.
- **Undefined:** no FIFO.
  - A request is issued only when the slot is empty or will be consumed at the ack edge.
  - While `id_halt`=1 with a valid slot, `imem_req`=0 (or stays high awaiting ack, with the result held in a single stall latch).

## Test plan
- Release reset, memory acks each cycle with data=addr -> `imem_addr` 0,4,8,…; `if_pc`/`if_instr` sequence 0,4,8 on consecutive cycles with no bubbles after the first.
- `id_halt`=1 for 3 cycles with slot pc=8 -> `if_pc`=8 held all 3 cycles. With PREFETCH_EN, `imem_addr` reaches 0x14 and then `imem_req`=0. On release, 0xC,0x10,0x14 are presented back-to-back.
- `branch`=1, target=0x103, while a request to 0x20 waits 2 cycles for ack -> 0x20 data discarded; next request is to 0x100; one or more bubbles; `if_pc`=0x100.
- `id_flush` with slot pc=0x40 valid -> bubble presented; refetch starts at 0x40.
- Ack with `imem_err`=1 at addr 0x80 -> `if_err`=1, `if_instr`=`{OPCODE_NOP,26'(3)}`, `if_pc`=0x80; no further `imem_req` until `branch` to 0x200.
- Assert `rst`=0 mid-request -> next sample shows `imem_req`=0 and outputs at reset values; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_if.sv
// core_if: instruction fetch stage of the i2d core.
// Build option: define I2D_IF_PREFETCH_EN to add a 2-entry prefetch FIFO between the bus and the slot.
// Purpose: owns the fetch PC, issues word requests and presents one instruction per cycle to decode.
// Latency: an ack at edge N is visible on if_pc/if_instr after edge N when the slot is consumable.
// Backpressure: id_halt freezes the slot; fetch stops once there is no room for a returning word.
module core_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_halt,
  input  logic        id_flush,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_err,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        imem_err
);

  localparam logic [5:0]  OPCODE_NOP = 6'h13;
  localparam logic [31:0] NOP_BUBBLE = {OPCODE_NOP, 26'd0};
  localparam logic [31:0] NOP_FAULT  = {OPCODE_NOP, 26'd3};

  typedef enum logic [1:0] {S_RST, S_FETCH, S_DRAIN, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] redir_pc;     // where to resume once a drained request acks
  logic        hold;         // FETCH request raised earlier and still unacked
  logic        slot_valid;

  // Small in-order buffer; with prefetch disabled it never holds more than
  // one word and acts as the stall latch for an ack that lands during a halt.
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        buf_err   [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  buf_cnt;

  logic        kill, slot_load, ack_ok, take_data, buf_empty, push, pop, room;
  logic [31:0] tgt_pc, flush_pc, restart_pc, ack_instr;
  logic        unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target[1:0];

  assign kill       = branch | id_flush;
  assign slot_load  = !id_halt && !kill;
  assign ack_ok     = imem_req && imem_ack;
  assign take_data  = ack_ok && (state == S_FETCH) && !kill;
  assign buf_empty  = (buf_cnt == 2'd0);
  assign pop        = slot_load && !buf_empty;
  assign push       = take_data && !(slot_load && buf_empty);
  assign ack_instr  = imem_err ? NOP_FAULT : imem_data;
  assign tgt_pc     = {branch_target[31:2], 2'b00};
  // Oldest discarded valid instruction: slot, then buffer head, then the fetch PC.
  assign flush_pc   = slot_valid ? if_pc : (!buf_empty ? buf_pc[rd_ptr] : fetch_pc);
  assign restart_pc = branch ? tgt_pc : flush_pc;
  assign imem_addr  = fetch_pc;

`ifdef I2D_IF_PREFETCH_EN
  // A full buffer still has room when decode drains its head at this edge.
  assign room = (buf_cnt != 2'd2) || !id_halt;
`else
  // Only fetch when the word can reach the slot, or an empty slot is frozen by a halt.
  assign room = !id_halt || (buf_empty && !slot_valid);
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= state_nxt;
  end

  // Next state and bus request; no new request starts in a redirect/flush cycle
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_RST:   state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = hold || (room && !kill);
        if (kill)
          state_nxt = (hold && !imem_ack) ? S_DRAIN : S_FETCH;
        else if (imem_req && imem_ack && imem_err)
          state_nxt = S_ERR;
      end
      S_DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_FETCH;
      end
      S_ERR:   if (branch) state_nxt = S_FETCH;
      default: state_nxt = S_RST;
    endcase
  end

  // Fetch PC, pending redirect target and in-flight tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      redir_pc <= RESET_PC;
      hold     <= 1'b0;
    end else begin
      hold <= (state == S_FETCH) && imem_req && !imem_ack && !kill;
      case (state)
        S_RST:   fetch_pc <= RESET_PC;
        S_FETCH: begin
          if (kill) begin
            if (hold && !imem_ack) redir_pc <= restart_pc;
            else                   fetch_pc <= restart_pc;
          end else if (take_data) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        S_DRAIN: begin
          if (imem_ack)    fetch_pc <= branch ? tgt_pc : redir_pc;
          else if (branch) redir_pc <= tgt_pc;
        end
        S_ERR:   if (branch) fetch_pc <= tgt_pc;
        default: ;
      endcase
    end
  end

  // Output slot and buffer occupancy; slot reloads only when decode consumes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= 1'b0;
      if_pc      <= 32'd0;
      if_instr   <= NOP_BUBBLE;
      if_err     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else if (kill) begin
      slot_valid <= 1'b0;
      if_instr   <= NOP_BUBBLE;
      if_err     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      if (slot_load) begin
        if (pop) begin
          slot_valid <= 1'b1;
          if_pc      <= buf_pc[rd_ptr];
          if_instr   <= buf_instr[rd_ptr];
          if_err     <= buf_err[rd_ptr];
        end else if (take_data) begin
          slot_valid <= 1'b1;
          if_pc      <= fetch_pc;
          if_instr   <= ack_instr;
          if_err     <= imem_err;
        end else begin
          slot_valid <= 1'b0;
          if_instr   <= NOP_BUBBLE;
          if_err     <= 1'b0;
        end
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= ack_instr;
      buf_err[wr_ptr]   <= imem_err;
    end
  end

endmodule

// File: tb/tb_core_if.sv
// Bench for core_if: directed scenarios followed by a randomized run, all checked
// against an instruction-stream model (next expected PC, memory word = addr ^ key).
module tb_core_if;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE   = 32'h4C00_0000;  // {6'h13, 26'd0}
  localparam logic [31:0] FAULT    = 32'h4C00_0003;  // {6'h13, 26'd3}
  localparam logic [31:0] KEY      = 32'h5A00_0000;
`ifdef I2D_IF_PREFETCH_EN
  localparam logic [31:0] HALT_ADDR = 32'h14;
`else
  localparam logic [31:0] HALT_ADDR = 32'h0C;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_halt, id_flush, branch;
  logic [31:0] branch_target;
  logic [31:0] if_pc, if_instr;
  logic        if_err;
  logic        imem_req, imem_ack, imem_err;
  logic [31:0] imem_addr, imem_data;

  always #5 clk = ~clk;

  core_if #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .id_halt(id_halt), .id_flush(id_flush),
    .branch(branch), .branch_target(branch_target),
    .if_pc(if_pc), .if_instr(if_instr), .if_err(if_err),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_err(imem_err)
  );

  // Memory responder: acks once the request has waited the chosen latency.
  logic [3:0]  wait_cnt, cur_lat, fixed_lat, max_lat;
  logic        rand_lat, err_en;
  logic [31:0] err_addr;

  assign imem_ack  = imem_req && (wait_cnt >= (rand_lat ? cur_lat : fixed_lat));
  assign imem_data = imem_addr ^ KEY;
  assign imem_err  = err_en && (imem_addr == err_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
      cur_lat  <= 4'd0;
    end else begin
      if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
      else                       wait_cnt <= 4'd0;
      if (imem_req && imem_ack)  cur_lat <= 4'($urandom_range(0, int'(max_lat)));
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid, bub, base;
  logic        found, seen;
  // stream model
  logic [31:0] exp_pc;
  logic        faulted;
  logic [31:0] prev_pc, prev_instr;
  logic        prev_err;
  logic        pend;
  logic [31:0] pend_addr;
  logic        p_req, p_ack;
  logic [31:0] p_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check the bus before the edge, check the slot after it.
  task automatic step(input logic h, input logic f, input logic b, input logic [31:0] t);
    id_halt = h; id_flush = f; branch = b; branch_target = t;
    prev_pc = if_pc; prev_instr = if_instr; prev_err = if_err;
    #4;
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    if (pend) begin
      chk("req_held", 32'(p_req), 32'd1);
      chk("addr_held", p_addr, pend_addr);
    end
    if (faulted) chk("no_req_in_err", 32'(p_req), 32'd0);
    pend = p_req && !p_ack;
    pend_addr = p_addr;
    @(posedge clk); #1;
    if (b || f) begin
      chk("kill_bubble", if_instr, BUBBLE);
      chk("kill_err", 32'(if_err), 32'd0);
      if (b) begin
        exp_pc  = {t[31:2], 2'b00};
        faulted = 1'b0;
      end else if (prev_instr != BUBBLE || prev_err) begin
        exp_pc = prev_pc;
      end
    end else if (h) begin
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_instr", if_instr, prev_instr);
      chk("hold_err", 32'(if_err), 32'(prev_err));
    end else if (if_err) begin
      chk("fault_expected", 32'(err_en), 32'd1);
      chk("fault_pc", if_pc, exp_pc);
      chk("fault_instr", if_instr, FAULT);
      faulted = 1'b1;
    end else if (if_instr != BUBBLE) begin
      chk("pc", if_pc, exp_pc);
      chk("instr", if_instr, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      n_valid++;
    end
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC; faulted = 1'b0; pend = 1'b0;
  endtask

  initial begin
    rst = 1'b0; id_halt = 1'b0; id_flush = 1'b0; branch = 1'b0; branch_target = 32'd0;
    fixed_lat = 4'd0; max_lat = 4'd0; rand_lat = 1'b0; err_en = 1'b0; err_addr = 32'h80;
    n_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, BUBBLE);
    chk("rst_if_err", 32'(if_err), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    rst = 1'b1;

    // Zero-wait streaming: 0,4,8 back to back
    found = 1'b0; seen = 1'b0; bub = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      if (if_instr != BUBBLE) begin
        seen = 1'b1;
        if (if_pc == 32'h8) found = 1'b1;
      end else if (seen) bub++;
    end
    chk("reach_pc8", 32'(found), 32'd1);
    chk("no_bubbles", 32'(bub), 32'd0);

    // Halt three cycles with pc=8 in the slot
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("halt_req", 32'(p_req), 32'd0);
    chk("halt_addr", p_addr, HALT_ADDR);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("release_pc0", if_pc, 32'h0C);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("release_pc1", if_pc, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("release_pc2", if_pc, 32'h14);

    // Redirect while the request to 0x20 waits for its ack
    for (int k = 0; k < 20 && imem_addr != 32'h20; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("reach_0x20", imem_addr, 32'h20);
    fixed_lat = 4'd2;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h103);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("drain_ack", 32'(p_ack), 32'd1);
    chk("drain_addr", p_addr, 32'h20);
    chk("drain_bubble", if_instr, BUBBLE);
    fixed_lat = 4'd0;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("redir_req", 32'(p_req), 32'd1);
    chk("redir_addr", p_addr, 32'h100);
    chk("redir_pc", if_pc, 32'h100);

    // Flush with pc=0x40 valid in the slot
    step(1'b0, 1'b0, 1'b1, 32'h38);
    for (int k = 0; k < 20 && !(if_pc == 32'h40 && if_instr != BUBBLE); k++)
      step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("reach_0x40", if_pc, 32'h40);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("flush_req", 32'(p_req), 32'd1);
    chk("flush_addr", p_addr, 32'h40);
    chk("flush_pc", if_pc, 32'h40);

    // Bus error at 0x80
    err_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 32'h78);
    for (int k = 0; k < 20 && !if_err; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("err_flag", 32'(if_err), 32'd1);
    chk("err_pc", if_pc, 32'h80);
    chk("err_instr", if_instr, FAULT);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("err_quiet", 32'(p_req), 32'd0);
    err_en = 1'b0;
    step(1'b0, 1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("err_redir_req", 32'(p_req), 32'd1);
    chk("err_redir_addr", p_addr, 32'h200);

    // Reset while a request waits
    fixed_lat = 4'd3;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_pending", 32'(pend), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    chk("mid_rst_pc", if_pc, 32'd0);
    chk("mid_rst_instr", if_instr, BUBBLE);
    chk("mid_rst_err", 32'(if_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    fixed_lat = 4'd0;
    model_reset();
    for (int k = 0; k < 10 && if_instr == BUBBLE; k++) step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart_pc", if_pc, RESET_PC);

    // Randomized run against the stream model
    rand_lat = 1'b1; max_lat = 4'd3;
    base = n_valid;
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(($urandom_range(0, 9) < 3), (r < 3), (r >= 97), 32'($urandom_range(0, 1023)));
    end
    chk("progress", 32'((n_valid - base) >= 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
